// File: rtl/arb_mux_if.sv
// Channel-side and output-side handshake bundle for arb_mux.
// The master modport is the environment; the slave modport is the arbiter.
interface arb_mux_if #(
    parameter int bit_size = 18,
    parameter int ch_num   = 4,
    parameter int sel_size = 2
);
    // Valid/ready: a word moves on a rising edge where both valid and ready
    // are 1. Input ready depends combinationally on valid; output valid never
    // depends on output ready, and a presented word stays put until taken.
    logic                         mode;
    logic [sel_size-1:0]          S;
    logic [ch_num-1:0]            in_valid;
    logic [ch_num*bit_size-1:0]   in_data;
    logic [ch_num-1:0]            in_ready;
    logic                         out_valid;
    logic [bit_size-1:0]          out_data;
    logic [sel_size-1:0]          out_ch;
    logic                         out_ready;

    modport master (
        output mode,
        output S,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_ch
    );

    modport slave (
        input  mode,
        input  S,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_ch
    );
endinterface

// File: rtl/arb_mux.sv
// Multi-channel arbiter/mux with a single registered output slot.
// Fixed-select or round-robin grant; one word per cycle under steady out_ready.
module arb_mux #(
    parameter int bit_size = 18,
    parameter int ch_num   = 4,
    parameter int sel_size = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    arb_mux_if.slave bus
);
    localparam logic [sel_size:0]   CH_NUM_W = (sel_size+1)'(ch_num);
    localparam logic [sel_size-1:0] LAST_CH  = sel_size'(ch_num - 1);

    logic                 slot_open;
    logic                 fix_vld;
    logic                 rr_vld;
    logic [sel_size-1:0]  rr_idx;
    logic [sel_size:0]    rr_scan;
    logic                 grant_vld;
    logic [sel_size-1:0]  grant_idx;
    logic [bit_size-1:0]  grant_data;

    logic                 out_valid_q, out_valid_d;
    logic [bit_size-1:0]  out_data_q,  out_data_d;
    logic [sel_size-1:0]  out_ch_q,    out_ch_d;
    logic [sel_size-1:0]  ptr_q,       ptr_d;

    assign slot_open = !out_valid_q || bus.out_ready;

    // An S outside 0..ch_num-1 matches no channel, so it simply never grants.
    always_comb begin
        fix_vld = 1'b0;
        for (int i = 0; i < ch_num; i++) begin
            if (bus.S == sel_size'(i) && bus.in_valid[i]) begin
                fix_vld = 1'b1;
            end
        end
    end

    // Scan ptr, ptr+1, ... with an explicit wrap at ch_num, since ch_num
    // need not be a power of two and the index cannot just overflow.
    always_comb begin
        rr_vld  = 1'b0;
        rr_idx  = '0;
        rr_scan = '0;
        for (int k = 0; k < ch_num; k++) begin
            rr_scan = {1'b0, ptr_q} + (sel_size+1)'(k);
            if (rr_scan >= CH_NUM_W) begin
                rr_scan = rr_scan - CH_NUM_W;
            end
            if (!rr_vld && bus.in_valid[rr_scan[sel_size-1:0]]) begin
                rr_vld = 1'b1;
                rr_idx = rr_scan[sel_size-1:0];
            end
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (slot_open) begin
            if (bus.mode) begin
                grant_vld = rr_vld;
                grant_idx = rr_idx;
            end else begin
                grant_vld = fix_vld;
                grant_idx = bus.S;
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < ch_num; i++) begin
            if (grant_idx == sel_size'(i)) begin
                grant_data = bus.in_data[i*bit_size +: bit_size];
            end
        end
    end

    // Gated by rst_n so no channel sees an accept while reset is held.
    always_comb begin
        bus.in_ready = '0;
        if (rst_n && grant_vld) begin
            for (int i = 0; i < ch_num; i++) begin
                bus.in_ready[i] = (grant_idx == sel_size'(i));
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (slot_open) begin
            out_valid_d = grant_vld;
            if (grant_vld) begin
                out_data_d = grant_data;
                out_ch_d   = grant_idx;
            end
        end
        if (grant_vld && bus.mode) begin
            ptr_d = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: a 4-channel and a 3-channel instance share clk/rst_n.
// Stimulus pushes expected {ch,data} words; per-instance monitors pop on output transfers.
module tb_arb_mux;
    localparam int BW = 18;
    localparam int SW = 2;
    localparam int W  = BW + SW;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    logic [W-1:0]  exp_qa[$];
    logic [W-1:0]  exp_qb[$];
    logic [BW-1:0] da[4];
    logic [BW-1:0] db[3];

    arb_mux_if #(.bit_size(BW), .ch_num(4), .sel_size(SW)) ifa ();
    arb_mux_if #(.bit_size(BW), .ch_num(3), .sel_size(SW)) ifb ();

    arb_mux #(.bit_size(BW), .ch_num(4), .sel_size(SW)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    arb_mux #(.bit_size(BW), .ch_num(3), .sel_size(SW)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a();
        for (int i = 0; i < 4; i++) ifa.in_data[i*BW +: BW] = da[i];
    endtask

    task automatic load_b();
        for (int i = 0; i < 3; i++) ifb.in_data[i*BW +: BW] = db[i];
    endtask

    // Monitors: every negedge with out_valid && out_ready is exactly one transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && ifa.out_valid && ifa.out_ready) begin
                if (exp_qa.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL mon_a_unexpected: got %0h, expected no word (t=%0t)",
                             {ifa.out_ch, ifa.out_data}, $time);
                end else begin
                    check("mon_a_word", 32'({ifa.out_ch, ifa.out_data}), 32'(exp_qa.pop_front()));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && ifb.out_valid && ifb.out_ready) begin
                if (exp_qb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL mon_b_unexpected: got %0h, expected no word (t=%0t)",
                             {ifb.out_ch, ifb.out_data}, $time);
                end else begin
                    check("mon_b_word", 32'({ifb.out_ch, ifb.out_data}), 32'(exp_qb.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        da[0] = 18'h01234; da[1] = 18'h15555; da[2] = 18'h2AAAA; da[3] = 18'h3CCCC;
        db[0] = 18'h00ABC; db[1] = 18'h1DEAD; db[2] = 18'h3F00F;
        rst_n = 1'b0;
        ifa.mode = 1'b1; ifa.S = '0; ifa.in_valid = '1; ifa.out_ready = 1'b0; load_a();
        ifb.mode = 1'b1; ifb.S = '0; ifb.in_valid = '1; ifb.out_ready = 1'b0; load_b();

        // Reset values, before any clock edge
        #2;
        check("rst_out_valid", 32'(ifa.out_valid), 32'd0);
        check("rst_out_data",  32'(ifa.out_data),  32'd0);
        check("rst_out_ch",    32'(ifa.out_ch),    32'd0);
        check("rst_in_ready_a", 32'(ifa.in_ready), 32'd0);
        check("rst_in_ready_b", 32'(ifb.in_ready), 32'd0);
        step();
        step();

        // Fixed select S=2, granted in the first cycle after reset release
        rst_n = 1'b1;
        ifb.in_valid = '0; ifb.out_ready = 1'b1;
        ifa.mode = 1'b0; ifa.S = 2'd2; ifa.in_valid = 4'b0111; ifa.out_ready = 1'b1;
        exp_qa.push_back({2'd2, 18'h2AAAA});
        #3 check("fix_in_ready", 32'(ifa.in_ready), 32'b0100);
        step();
        ifa.in_valid = '0;
        #3;
        check("fix_out_valid", 32'(ifa.out_valid), 32'd1);
        check("fix_out_data",  32'(ifa.out_data),  32'h2AAAA);
        check("fix_out_ch",    32'(ifa.out_ch),    32'd2);
        check("idle_in_ready", 32'(ifa.in_ready),  32'd0);
        step();
        #3;
        check("idle_out_valid", 32'(ifa.out_valid), 32'd0);
        check("idle_hold_data", 32'(ifa.out_data),  32'h2AAAA);
        check("idle_hold_ch",   32'(ifa.out_ch),    32'd2);

        // Round robin, all requesting: ptr untouched by the fixed grant, so 0,1,2,3,0,1
        step();
        ifa.mode = 1'b1; ifa.in_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            exp_qa.push_back({2'(k % 4), da[k % 4]});
            #3;
            check("rr_in_ready", 32'(ifa.in_ready), 32'(1 << (k % 4)));
            if (k > 0) begin
                check("rr_no_bubble", 32'(ifa.out_valid), 32'd1);
                check("rr_out_ch", 32'(ifa.out_ch), 32'((k - 1) % 4));
            end
            step();
        end
        ifa.in_valid = '0;
        #3 check("rr_last_ch", 32'(ifa.out_ch), 32'd1);

        // Backpressure with ch1 word held; mode/S flip while held must not disturb it
        step();
        ifa.mode = 1'b0; ifa.S = 2'd1; ifa.in_valid = 4'b0010;
        exp_qa.push_back({2'd1, 18'h15555});
        #3 check("bp_first_ready", 32'(ifa.in_ready), 32'b0010);
        step();
        ifa.out_ready = 1'b0; ifa.in_valid = 4'b1111;
        da[1] = 18'h1BEEF; load_a();
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin ifa.mode = 1'b1; ifa.S = 2'd3; end
            if (k == 2) begin ifa.mode = 1'b0; ifa.S = 2'd1; end
            #3;
            check("bp_in_ready",  32'(ifa.in_ready),  32'd0);
            check("bp_out_valid", 32'(ifa.out_valid), 32'd1);
            check("bp_out_ch",    32'(ifa.out_ch),    32'd1);
            check("bp_out_data",  32'(ifa.out_data),  32'h15555);
            step();
        end
        ifa.out_ready = 1'b1;
        exp_qa.push_back({2'd1, 18'h1BEEF});
        #3 check("bp_release_ready", 32'(ifa.in_ready), 32'b0010);
        step();
        ifa.in_valid = '0;
        #3;
        check("bp_next_valid", 32'(ifa.out_valid), 32'd1);
        check("bp_next_data",  32'(ifa.out_data),  32'h1BEEF);

        // Load ch3 word, hold it, then reset mid-cycle: the word is discarded
        step();
        ifa.S = 2'd3; ifa.in_valid = 4'b1000;
        step();
        ifa.in_valid = '0; ifa.out_ready = 1'b0;
        #3;
        check("pre_rst_valid", 32'(ifa.out_valid), 32'd1);
        check("pre_rst_ch",    32'(ifa.out_ch),    32'd3);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(ifa.out_valid), 32'd0);
        check("async_rst_data",  32'(ifa.out_data),  32'd0);
        check("async_rst_ch",    32'(ifa.out_ch),    32'd0);
        step();

        // After reset ptr is 0 again, so round robin grants ch0 first
        rst_n = 1'b1;
        ifa.mode = 1'b1; ifa.in_valid = 4'b1111; ifa.out_ready = 1'b1;
        exp_qa.push_back({2'd0, 18'h01234});
        #3 check("post_rst_ready", 32'(ifa.in_ready), 32'b0001);
        step();
        ifa.in_valid = '0;
        #3 check("post_rst_ch", 32'(ifa.out_ch), 32'd0);
        step();

        // 3-channel instance: grant ch1 to set ptr=2, then 3'b101 gives 2,0,2,0
        ifb.mode = 1'b1; ifb.in_valid = 3'b010;
        exp_qb.push_back({2'd1, 18'h1DEAD});
        #3 check("b_rr_seed", 32'(ifb.in_ready), 32'b010);
        for (int k = 0; k < 4; k++) begin
            step();
            ifb.in_valid = 3'b101;
            if (k % 2 == 0) begin
                exp_qb.push_back({2'd2, 18'h3F00F});
                #3 check("b_wrap_ready", 32'(ifb.in_ready), 32'b100);
            end else begin
                exp_qb.push_back({2'd0, 18'h00ABC});
                #3 check("b_wrap_ready", 32'(ifb.in_ready), 32'b001);
            end
        end

        // Out-of-range select on the 3-channel instance
        step();
        ifb.mode = 1'b0; ifb.S = 2'd3; ifb.in_valid = 3'b111;
        #3;
        check("b_oor_ready", 32'(ifb.in_ready),  32'd0);
        check("b_oor_valid", 32'(ifb.out_valid), 32'd1);
        check("b_oor_ch",    32'(ifb.out_ch),    32'd0);
        step();
        #3;
        check("b_oor_fall",  32'(ifb.out_valid), 32'd0);
        check("b_oor_ready2", 32'(ifb.in_ready), 32'd0);
        check("b_oor_hold",  32'(ifb.out_data),  32'h00ABC);

        step();
        ifb.in_valid = '0;
        step();
        step();
        check("qa_drained", 32'(exp_qa.size()), 32'd0);
        check("qb_drained", 32'(exp_qb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
